// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
// One op in flight; result held under a valid/ready response handshake.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       div_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_n;

  logic             accept;
  logic             op_signed;
  logic             op_mod;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  logic             mod_q;
  logic             s1_neg;
  logic             s2_neg;
  logic             dzero;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;
  logic             res_valid_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign req_ready = (state == IDLE) & ~flush;
  assign accept    = req_valid & req_ready;
  assign busy      = (state != IDLE);
  assign res_valid = res_valid_q;
  assign result    = result_q;

  // Non-one-hot encodings fall through as DIV.WU.
  always_comb begin
    op_signed = 1'b0;
    op_mod    = 1'b0;
    if ($onehot(div_op)) begin
      unique case (1'b1)
        div_op[0]: op_signed = 1'b1;
        div_op[1]: begin
          op_signed = 1'b1;
          op_mod    = 1'b1;
        end
        div_op[2]: op_mod = 1'b0;
        div_op[3]: op_mod = 1'b1;
      endcase
    end
  end

  always_comb begin
    a_abs = src1;
    b_abs = src2;
    if (op_signed && src1[WIDTH-1]) a_abs = -src1;
    if (op_signed && src2[WIDTH-1]) b_abs = -src2;
  end

  always_comb begin
    rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs};
  end

  // Remainder follows dividend sign; a zero divisor forces all-ones quotient.
  always_comb begin
    q_fix = quo;
    r_fix = rem[WIDTH-1:0];
    if (s1_neg ^ s2_neg) q_fix = -quo;
    if (s1_neg) r_fix = -rem[WIDTH-1:0];
    if (dzero) q_fix = '1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (req_valid) state_n = CALC;
        CALC: if (cnt == CNT_W'(WIDTH - 1)) state_n = FIX;
        FIX:  state_n = DONE;
        DONE: if (res_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mod_q       <= 1'b0;
      s1_neg      <= 1'b0;
      s2_neg      <= 1'b0;
      dzero       <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        mod_q  <= op_mod;
        s1_neg <= op_signed & src1[WIDTH-1];
        s2_neg <= op_signed & src2[WIDTH-1];
        dzero  <= (src2 == '0);
        rem    <= '0;
        quo    <= a_abs;
        dvs    <= b_abs;
        cnt    <= '0;
      end
      if (state == CALC) begin
        rem <= diff[WIDTH+1] ? rem_sh : diff[WIDTH:0];
        quo <= {quo[WIDTH-2:0], ~diff[WIDTH+1]};
        cnt <= cnt + 1'b1;
      end
      if (flush) begin
        res_valid_q <= 1'b0;
      end else if (state == FIX) begin
        result_q    <= mod_q ? r_fix : q_fix;
        res_valid_q <= 1'b1;
      end else if (state == DONE && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus handshake,
// backpressure, flush and mid-operation reset sequences.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   div_op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         flush;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         busy;

  int compared = 0;
  int mismatched = 0;

  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_MOD  = 4'b0010;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_MODU = 4'b1000;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  div_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .div_op    (div_op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input string nm);
    @(negedge clk);
    chk({nm, " req_ready"}, W'(req_ready), W'(1));
    req_valid = 1'b1;
    div_op    = op;
    src1      = a;
    src2      = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm, output int cyc);
    cyc = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        cyc = n;
        break;
      end
    end
    chk({nm, " latency"}, W'(cyc), W'(33));
  endtask

  task automatic take_res(input string nm);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk({nm, " res_valid after take"}, W'(res_valid), W'(0));
    chk({nm, " req_ready after take"}, W'(req_ready), W'(1));
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp,
                        input string nm);
    int cyc;
    start_op(op, a, b, nm);
    wait_res(nm, cyc);
    chk({nm, " result"}, result, exp);
    take_res(nm);
  endtask

  initial begin
    int cyc;
    logic [W-1:0] held;

    vecs[0] = '{"divw 7/2",        OP_DIV,  32'd7,        32'd2,        32'h00000003};
    vecs[1] = '{"modw -7/2",       OP_MOD,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[2] = '{"divw -7/2",       OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[3] = '{"modw 7/-2",       OP_MOD,  32'd7,        32'hFFFFFFFE, 32'h00000001};
    vecs[4] = '{"divwu ffff/10",   OP_DIVU, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF};
    vecs[5] = '{"modwu ffff/10",   OP_MODU, 32'hFFFFFFFF, 32'h10,       32'h0000000F};
    vecs[6] = '{"divw ovf",        OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[7] = '{"modw ovf",        OP_MOD,  32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[8] = '{"divw by0",        OP_DIV,  32'h12345678, 32'd0,        32'hFFFFFFFF};
    vecs[9] = '{"modwu by0",       OP_MODU, 32'h12345678, 32'd0,        32'h12345678};

    resetn    = 1'b0;
    req_valid = 1'b0;
    div_op    = OP_DIVU;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    res_ready = 1'b0;
    #22;
    chk("reset res_valid", W'(res_valid), W'(0));
    chk("reset result", result, W'(0));
    chk("reset busy", W'(busy), W'(0));
    chk("reset req_ready", W'(req_ready), W'(1));
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Backpressure: result must hold for 10 cycles with no new accept.
    start_op(OP_DIVU, 32'd1000, 32'd3, "bp");
    wait_res("bp", cyc);
    chk("bp result", result, 32'd333);
    held = result;
    req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp hold result", result, held);
      chk("bp hold res_valid", W'(res_valid), W'(1));
      chk("bp hold req_ready", W'(req_ready), W'(0));
    end
    req_valid = 1'b0;
    take_res("bp");

    // Flush together with a request: nothing accepted.
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("flush req_ready", W'(req_ready), W'(0));
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush no accept busy", W'(busy), W'(0));

    // Flush at step 15, then an immediate fresh op.
    held = result;
    start_op(OP_DIV, 32'd5000, 32'd7, "fl");
    repeat (14) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl busy", W'(busy), W'(0));
    chk("fl res_valid", W'(res_valid), W'(0));
    chk("fl result kept", result, held);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0000000E, "after flush");

    // Flush while holding a result in DONE, with res_ready also high.
    start_op(OP_MODU, 32'd100, 32'd7, "fd");
    wait_res("fd", cyc);
    chk("fd result", result, 32'd2);
    flush     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    res_ready = 1'b0;
    chk("fd res_valid", W'(res_valid), W'(0));
    chk("fd busy", W'(busy), W'(0));
    chk("fd result kept", result, 32'd2);

    // Asynchronous reset in the middle of CALC.
    start_op(OP_DIV, 32'd999, 32'd9, "rst");
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst busy", W'(busy), W'(0));
    chk("rst res_valid", W'(res_valid), W'(0));
    chk("rst result", result, W'(0));
    chk("rst req_ready", W'(req_ready), W'(1));
    @(negedge clk);
    resetn = 1'b1;
    run_op(OP_DIV, 32'd999, 32'd9, 32'd111, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative radix-2 integer divider; responder side of the divide request handshake issued by the execute stage.
- Accepts one DIV.W / MOD.W / DIV.WU / MOD.WU operation per request.
- Computes the quotient or remainder over 32 iteration cycles, then holds the result under a valid/ready response handshake until the memory stage consumes it.
- Supports pipeline flush (exception / ertn) cancelling an in-flight operation.

Parameters:
- WIDTH, 32, operand and result width
- CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage has a divide request
- req_ready  out  1  unit can accept a request this cycle
- div_op  in  4  one-hot: [0] DIV.W, [1] MOD.W, [2] DIV.WU, [3] MOD.WU
- src1  in  WIDTH  dividend
- src2  in  WIDTH  divisor
- flush  in  1  cancel any operation (ex_flush | ertn_flush)
- res_valid  out  1  result is available
- res_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  quotient or remainder per latched div_op
- busy  out  1  state != IDLE

Behaviour:
- Reset (resetn low, async): state=IDLE, res_valid=0, result=0, counter=0, all internal registers 0.
- req_ready = (state==IDLE) & ~flush. Accept = req_valid & req_ready.
- States and transitions:
  - IDLE: on accept, latch div_op, signedness, sign(src1), sign(src2), |src1|, |src2| (absolute values only for signed ops; otherwise raw) and a div-by-zero flag; go to CALC with counter=0.
  - CALC: one restoring step per cycle: shift {rem,quo} left 1, trial-subtract divisor, set quotient LSB on non-negative result. Counter increments; after the 32nd step, go to FIX.
  - FIX: apply sign correction. Quotient is negated if sign(src1)!=sign(src2). Remainder takes the sign of the dividend. Load result (quotient for DIV ops, remainder for MOD ops), set res_valid=1, go to DONE.
  - DONE: hold result and res_valid stable while res_ready=0. On res_ready=1, clear res_valid and go to IDLE.
- Latency: accept edge E0; steps on E1..E32; FIX on E33; res_valid high from E33 onward. No new request is accepted until the cycle after the response handshake (throughput 1 op per ≥35 cycles).
- Divide by zero (src2==0, any op): no exception. Quotient = all ones and remainder = src1 (raw, unsigned and signed alike). Uses the same latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF (DIV.W) gives quotient 0x80000000; MOD.W of the same operands gives 0. No exception.
- flush: highest priority. In any state, on the next edge state=IDLE and res_valid=0; result is left unchanged. Flush in the same cycle as req_valid means no accept.
- Simultaneous flush and res_ready in DONE: the flush wins, with the same outcome (IDLE, res_valid=0).
- Reset asserted mid-operation aborts immediately. After resetn deasserts, the unit is in IDLE with req_ready=1 (absent flush).
- Invalid div_op (not one-hot) is treated as DIV.WU. The verification bench flags it as a protocol violation.
- Width rules: internal partial remainder is WIDTH+1 bits. Negation is two's complement modulo 2^WIDTH.

Test Plan:
- DIV.W 7 / 2 -> result 0x00000003, res_valid exactly 33 cycles after accept. MOD.W 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFF (-1).
- DIV.WU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF. MOD.WU the same operands -> 0x0000000F.
- DIV.W 0x80000000 / 0xFFFFFFFF -> 0x80000000. MOD.W the same operands -> 0x00000000.
- DIV.W 0x12345678 / 0 -> 0xFFFFFFFF. MOD.WU 0x12345678 / 0 -> 0x12345678. No hang.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> result and res_valid stable, req_ready=0 throughout. Raise res_ready -> next cycle res_valid=0, req_ready=1.
- flush at step 15 of a DIV.W, then immediate new DIV.WU 100/7 -> no stale response, result 0x0000000E. Also: resetn pulse mid-CALC -> all outputs return to reset values asynchronously.
